control_paso: RTL and testbench



---
 rtl/paso_pkg.sv | 93 +++++++++
 rtl/contador_ocupacion.sv | 51 +++++
 rtl/control_paso.sv | 96 +++++++++
 tb/tb_control_paso.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/paso_pkg.sv
// Shared types for the gate passage controller: FSM states, sensor sample codes
// and the sensor-sequence transition table.
package paso_pkg;

    localparam int unsigned ANCHO_MUESTRA = 2;

    typedef enum logic [2:0] {
        REPOSO,
        ENT_A,
        ENT_AB,
        ENT_B,
        SAL_B,
        SAL_BA,
        SAL_A,
        ESPERA_LIBRE
    } estado_paso_t;

    // Sample codes are {sensor_a, sensor_b}, 1 = beam blocked
    localparam logic [ANCHO_MUESTRA-1:0] S_LIBRE = 2'b00;
    localparam logic [ANCHO_MUESTRA-1:0] S_A     = 2'b10;
    localparam logic [ANCHO_MUESTRA-1:0] S_B     = 2'b01;
    localparam logic [ANCHO_MUESTRA-1:0] S_AB    = 2'b11;

    // Sequence-only next state; every move into ESPERA_LIBRE from elsewhere is an illegal sequence
    function automatic estado_paso_t siguiente_estado(input estado_paso_t e,
                                                      input logic [ANCHO_MUESTRA-1:0] m);
        estado_paso_t s;
        s = e;
        case (e)
            REPOSO: begin
                case (m)
                    S_A:     s = ENT_A;
                    S_B:     s = SAL_B;
                    S_AB:    s = ESPERA_LIBRE;
                    default: s = REPOSO;
                endcase
            end
            ENT_A: begin
                case (m)
                    S_AB:    s = ENT_AB;
                    S_LIBRE: s = REPOSO;
                    S_B:     s = ESPERA_LIBRE;
                    default: s = ENT_A;
                endcase
            end
            ENT_AB: begin
                case (m)
                    S_B:     s = ENT_B;
                    S_A:     s = ENT_A;
                    S_LIBRE: s = ESPERA_LIBRE;
                    default: s = ENT_AB;
                endcase
            end
            ENT_B: begin
                case (m)
                    S_LIBRE: s = REPOSO;
                    S_AB:    s = ENT_AB;
                    S_A:     s = ESPERA_LIBRE;
                    default: s = ENT_B;
                endcase
            end
            SAL_B: begin
                case (m)
                    S_AB:    s = SAL_BA;
                    S_LIBRE: s = REPOSO;
                    S_A:     s = ESPERA_LIBRE;
                    default: s = SAL_B;
                endcase
            end
            SAL_BA: begin
                case (m)
                    S_A:     s = SAL_A;
                    S_B:     s = SAL_B;
                    S_LIBRE: s = ESPERA_LIBRE;
                    default: s = SAL_BA;
                endcase
            end
            SAL_A: begin
                case (m)
                    S_LIBRE: s = REPOSO;
                    S_AB:    s = SAL_BA;
                    S_B:     s = ESPERA_LIBRE;
                    default: s = SAL_A;
                endcase
            end
            default: begin
                s = (m == S_LIBRE) ? REPOSO : ESPERA_LIBRE;
            end
        endcase
        return s;
    endfunction

endpackage

// File: rtl/contador_ocupacion.sv
// Saturating up/down occupancy counter; sat_c_o flags an increment at capacity
// or a decrement at zero in the same cycle the request is presented.
module contador_ocupacion #(
    parameter int unsigned ANCHO_CONT = 8,
    parameter int unsigned CAPACIDAD  = 200
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  inc_i,
    input  logic                  dec_i,
    output logic [ANCHO_CONT-1:0] ocupacion_o,
    output logic                  lleno_o,
    output logic                  vacio_o,
    output logic                  sat_c_o
);

    localparam logic [ANCHO_CONT-1:0] CAP = ANCHO_CONT'(CAPACIDAD);

    logic [ANCHO_CONT-1:0] ocupacion_q, ocupacion_d;
    logic                  lleno_q, vacio_q;

    always_comb begin
        ocupacion_d = ocupacion_q;
        sat_c_o     = 1'b0;
        if (inc_i) begin
            if (ocupacion_q == CAP) sat_c_o = 1'b1;
            else                    ocupacion_d = ocupacion_q + ANCHO_CONT'(1);
        end else if (dec_i) begin
            if (ocupacion_q == '0) sat_c_o = 1'b1;
            else                   ocupacion_d = ocupacion_q - ANCHO_CONT'(1);
        end
    end

    // Flags are derived from the next count so they move together with ocupacion
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ocupacion_q <= '0;
            lleno_q     <= 1'b0;
            vacio_q     <= 1'b1;
        end else begin
            ocupacion_q <= ocupacion_d;
            lleno_q     <= (ocupacion_d == CAP);
            vacio_q     <= (ocupacion_d == '0);
        end
    end

    assign ocupacion_o = ocupacion_q;
    assign lleno_o     = lleno_q;
    assign vacio_o     = vacio_q;

endmodule

// File: rtl/control_paso.sv
// Single-lane gate passage controller: classifies A/B sensor sequences as entries or exits.
// Optional stall abort enabled by defining TIMEOUT_PASO_EN.
module control_paso
    import paso_pkg::*;
#(
    parameter int unsigned ANCHO_CONT     = 8,
    parameter int unsigned CAPACIDAD      = 200,
    parameter int unsigned TIMEOUT_CICLOS = 50_000_000,
    parameter int unsigned ANCHO_TMO      = 26
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sensor_a,
    input  logic                  sensor_b,
    output logic                  entrada_pulso,
    output logic                  salida_pulso,
    output logic [ANCHO_CONT-1:0] ocupacion,
    output logic                  lleno,
    output logic                  vacio,
    output logic                  error_pulso
);

    if (64'(CAPACIDAD) > ((64'd1 << ANCHO_CONT) - 64'd1)) begin : g_chk_cap
        $error("CAPACIDAD does not fit in ANCHO_CONT bits");
    end
    if ((64'd1 << ANCHO_TMO) <= 64'(TIMEOUT_CICLOS)) begin : g_chk_tmo
        $error("ANCHO_TMO too narrow for TIMEOUT_CICLOS");
    end

    logic [ANCHO_MUESTRA-1:0] muestra_c;
    estado_paso_t             estado_q, estado_d, estado_sig_c;
    logic                     tmo_c, ent_c, sal_c, err_fsm_c, sat_c;
    logic                     entrada_q, salida_q, error_q;

    assign muestra_c    = {sensor_a, sensor_b};
    assign estado_sig_c = siguiente_estado(estado_q, muestra_c);
    assign estado_d     = tmo_c ? ESPERA_LIBRE : estado_sig_c;

    // A passage completes when the last sensor clears from the final state of its path
    assign ent_c     = (estado_q == ENT_B) && (estado_d == REPOSO);
    assign sal_c     = (estado_q == SAL_A) && (estado_d == REPOSO);
    assign err_fsm_c = (estado_d == ESPERA_LIBRE) && (estado_q != ESPERA_LIBRE);

`ifdef TIMEOUT_PASO_EN
    logic [ANCHO_TMO-1:0] timer_q, timer_d;

    assign tmo_c = (estado_q != REPOSO) && (estado_q != ESPERA_LIBRE) &&
                   (timer_q == ANCHO_TMO'(TIMEOUT_CICLOS - 1));

    always_comb begin
        timer_d = timer_q + ANCHO_TMO'(1);
        if ((estado_d != estado_q) || (estado_d == REPOSO) || (estado_d == ESPERA_LIBRE))
            timer_d = '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) timer_q <= '0;
        else       timer_q <= timer_d;
    end
`else
    assign tmo_c = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado_q  <= REPOSO;
            entrada_q <= 1'b0;
            salida_q  <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            entrada_q <= ent_c;
            salida_q  <= sal_c;
            error_q   <= err_fsm_c | sat_c;
        end
    end

    contador_ocupacion #(
        .ANCHO_CONT (ANCHO_CONT),
        .CAPACIDAD  (CAPACIDAD)
    ) u_contador (
        .clk         (clk),
        .reset       (reset),
        .inc_i       (ent_c),
        .dec_i       (sal_c),
        .ocupacion_o (ocupacion),
        .lleno_o     (lleno),
        .vacio_o     (vacio),
        .sat_c_o     (sat_c)
    );

    assign entrada_pulso = entrada_q;
    assign salida_pulso  = salida_q;
    assign error_pulso   = error_q;

endmodule

// File: tb/tb_control_paso.sv
// Bench for control_paso: directed passages plus random sensor traffic checked
// against a progress-along-the-word reference model.
module tb_control_paso;

    localparam int unsigned ANCHO_CONT     = 8;
    localparam int unsigned CAPACIDAD      = 3;
    localparam int unsigned TIMEOUT_CICLOS = 16;
    localparam int unsigned ANCHO_TMO      = 5;
`ifdef TIMEOUT_PASO_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  sensor_a, sensor_b;
    logic                  entrada_pulso, salida_pulso, lleno, vacio, error_pulso;
    logic [ANCHO_CONT-1:0] ocupacion;

    always #5 clk = ~clk;

    control_paso #(
        .ANCHO_CONT     (ANCHO_CONT),
        .CAPACIDAD      (CAPACIDAD),
        .TIMEOUT_CICLOS (TIMEOUT_CICLOS),
        .ANCHO_TMO      (ANCHO_TMO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .sensor_a      (sensor_a),
        .sensor_b      (sensor_b),
        .entrada_pulso (entrada_pulso),
        .salida_pulso  (salida_pulso),
        .ocupacion     (ocupacion),
        .lleno         (lleno),
        .vacio         (vacio),
        .error_pulso   (error_pulso)
    );

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    task automatic comprobar(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Model: passage direction (0 idle, 1 entry, 2 exit, 3 waiting for clear), position in word
    int m_dir, m_pos, m_age, m_occ;
    bit e_ent, e_sal, e_err;

    function automatic logic [1:0] letra(input int dir, input int pos);
        if (dir == 1) return (pos == 0) ? 2'b10 : (pos == 1) ? 2'b11 : 2'b01;
        else          return (pos == 0) ? 2'b01 : (pos == 1) ? 2'b11 : 2'b10;
    endfunction

    task automatic modelo_reset();
        m_dir = 0; m_pos = 0; m_age = 0; m_occ = 0;
        e_ent = 0; e_sal = 0; e_err = 0;
    endtask

    task automatic modelo(input logic [1:0] m);
        int nd, np;
        bit ent, sal, err;
        nd = m_dir; np = m_pos; ent = 0; sal = 0; err = 0;
        if (TMO_EN && (m_dir == 1 || m_dir == 2) && m_age == int'(TIMEOUT_CICLOS) - 1) begin
            nd = 3; err = 1;
        end else if (m_dir == 0) begin
            if (m == 2'b10)      begin nd = 1; np = 0; end
            else if (m == 2'b01) begin nd = 2; np = 0; end
            else if (m == 2'b11) begin nd = 3; err = 1; end
        end else if (m_dir == 3) begin
            if (m == 2'b00) nd = 0;
        end else begin
            if (m == letra(m_dir, m_pos)) begin
            end else if (m_pos < 2 && m == letra(m_dir, m_pos + 1)) np = m_pos + 1;
            else if (m_pos > 0 && m == letra(m_dir, m_pos - 1))     np = m_pos - 1;
            else if (m == 2'b00 && m_pos == 0)                      nd = 0;
            else if (m == 2'b00 && m_pos == 2) begin
                nd = 0;
                if (m_dir == 1) ent = 1; else sal = 1;
            end else begin
                nd = 3; err = 1;
            end
        end
        if (nd == 0 || nd == 3) np = 0;
        if (ent) begin
            if (m_occ == int'(CAPACIDAD)) err = 1; else m_occ++;
        end
        if (sal) begin
            if (m_occ == 0) err = 1; else m_occ--;
        end
        if (nd != m_dir || np != m_pos || !(nd == 1 || nd == 2)) m_age = 0;
        else m_age++;
        m_dir = nd; m_pos = np;
        e_ent = ent; e_sal = sal; e_err = err;
    endtask

    task automatic comprobar_salidas(input string fase);
        comprobar({fase, "_entrada"}, 32'(entrada_pulso), 32'(e_ent));
        comprobar({fase, "_salida"},  32'(salida_pulso),  32'(e_sal));
        comprobar({fase, "_error"},   32'(error_pulso),   32'(e_err));
        comprobar({fase, "_ocup"},    32'(ocupacion),     32'(m_occ));
        comprobar({fase, "_lleno"},   32'(lleno),         32'(m_occ == int'(CAPACIDAD)));
        comprobar({fase, "_vacio"},   32'(vacio),         32'(m_occ == 0));
    endtask

    task automatic paso(input logic [1:0] m);
        sensor_a = m[1];
        sensor_b = m[0];
        modelo(m);
        @(posedge clk);
        #1;
        comprobar_salidas("ciclo");
    endtask

    task automatic mantener(input logic [1:0] m, input int n);
        repeat (n) paso(m);
    endtask

    task automatic pasaje(input int dir, input int h);
        for (int p = 0; p < 3; p++) mantener(letra(dir, p), h);
        mantener(2'b00, h);
    endtask

    task automatic reset_async();
        #2 reset = 1'b1;
        #1;
        modelo_reset();
        comprobar_salidas("rst");
        #2 reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        sensor_a = 1'b0;
        sensor_b = 1'b0;
        modelo_reset();
        repeat (2) @(posedge clk);
        #1;
        comprobar_salidas("inicio");
        reset = 1'b0;

        pasaje(1, 4);
        comprobar("t1_ocup", 32'(ocupacion), 32'd1);
        pasaje(2, 4);
        comprobar("t2_ocup", 32'(ocupacion), 32'd0);
        comprobar("t2_vacio", 32'(vacio), 32'd1);
        mantener(2'b10, 2); mantener(2'b11, 2); mantener(2'b10, 2); mantener(2'b00, 2);
        comprobar("t3_ocup", 32'(ocupacion), 32'd0);

        repeat (4) pasaje(1, 2);
        comprobar("t4_ocup", 32'(ocupacion), 32'(CAPACIDAD));
        comprobar("t4_lleno", 32'(lleno), 32'd1);
        repeat (4) pasaje(2, 2);
        comprobar("t4_drenado", 32'(ocupacion), 32'd0);

        mantener(2'b10, 20);
        mantener(2'b11, 2); mantener(2'b01, 2); mantener(2'b00, 2);

        repeat (2) pasaje(1, 1);
        mantener(2'b10, 2); mantener(2'b11, 2);
        reset_async();
        comprobar("t6_ocup", 32'(ocupacion), 32'd0);
        mantener(2'b01, 3); mantener(2'b00, 3);

        for (int i = 0; i < 300; i++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 6) begin
                int dir;
                dir = $urandom_range(1, 2);
                mantener(letra(dir, 0), $urandom_range(1, 3));
                mantener(letra(dir, 1), $urandom_range(1, 3));
                if ($urandom_range(0, 4) == 0) begin
                    mantener(letra(dir, 0), $urandom_range(1, 2));
                    mantener(letra(dir, 1), $urandom_range(1, 2));
                end
                mantener(letra(dir, 2), $urandom_range(1, 3));
                mantener(2'b00, $urandom_range(1, 3));
            end else if (r < 9) begin
                mantener(2'($urandom_range(0, 3)), $urandom_range(1, 20));
            end else begin
                reset_async();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
